// File: rtl/lsu_bus_seq_pkg.sv
// Shared types and helpers for the load/store bus sequencer.
// Holds the FSM state encoding, the wait-counter width and the high-byte address step.
package lsu_bus_seq_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_LO   = 2'd1,
    LSU_HI   = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  localparam int unsigned LSU_WAIT_W = 8;

  // Address of the high byte; page_wrap keeps it inside the 256-byte page.
  function automatic logic [15:0] lsu_inc_adr(input logic [15:0] adr, input logic page_wrap);
    logic [15:0] nxt;
    if (page_wrap) begin
      nxt = {adr[15:8], adr[7:0] + 8'd1};
    end else begin
      nxt = adr + 16'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lsu_wait_timer.sv
// Per-byte-cycle wait counter: counts edges spent waiting on the bus and flags expiry.
// With TIMEOUT=0 the counter is held at zero and the expire flag is constant 0.
module lsu_wait_timer
  import lsu_bus_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam bit                    TimerOn = (TIMEOUT != 0);
  localparam logic [LSU_WAIT_W-1:0] LastCnt = LSU_WAIT_W'(TIMEOUT - 1);

  logic [LSU_WAIT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || !TimerOn) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + LSU_WAIT_W'(1);
    end
  end

  // Fires on the edge whose wait would bring the count to TIMEOUT.
  assign o_expire = TimerOn && i_en && (r_cnt == LastCnt);

endmodule

// File: rtl/lsu_bus_seq.sv
// Load/store sequencer: splits 8/16-bit ALU transfers into little-endian byte cycles on the
// 8-bit memory bus, with registered strobes/address and an optional per-byte wait timeout.
module lsu_bus_seq
  import lsu_bus_seq_pkg::*;
#(
  parameter int unsigned PAGE_WRAP = 0,
  parameter int unsigned TIMEOUT   = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sched_req,
  input  logic        i_sched_we,
  input  logic        i_sched_word,
  output logic        o_lsu_busy,
  output logic        o_lsu_done,
  output logic        o_lsu_fault,
  input  logic [15:0] i_alu_adr,
  input  logic [15:0] i_alu_payload,
  output logic [15:0] o_rf_load,
  output logic        o_rf_load_we,
  output logic [15:0] o_mem_adr,
  output logic [7:0]  o_mem_dout,
  input  logic [7:0]  i_mem_din,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  input  logic        i_mem_rdy
);

  lsu_state_e  r_state, w_state_d;
  logic [15:0] r_adr, w_adr_d;
  logic [7:0]  r_pay_hi, w_pay_hi_d;
  logic        r_we, w_we_d;
  logic        r_word, w_word_d;
  logic [7:0]  r_lo, w_lo_d;
  logic        r_fault, w_fault_d;
  logic [15:0] r_mem_adr, w_mem_adr_d;
  logic [7:0]  r_mem_dout, w_mem_dout_d;
  logic        r_mem_rd, w_mem_rd_d;
  logic        r_mem_wr, w_mem_wr_d;
  logic [15:0] r_rf_load, w_rf_load_d;

  logic w_xfer;
  logic w_expire;

  assign w_xfer = (r_state == LSU_LO) || (r_state == LSU_HI);

  lsu_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (!w_xfer || i_mem_rdy),
    .i_en    (w_xfer && !i_mem_rdy),
    .o_expire(w_expire)
  );

  always_comb begin
    w_state_d    = r_state;
    w_adr_d      = r_adr;
    w_pay_hi_d   = r_pay_hi;
    w_we_d       = r_we;
    w_word_d     = r_word;
    w_lo_d       = r_lo;
    w_fault_d    = r_fault;
    w_mem_adr_d  = r_mem_adr;
    w_mem_dout_d = r_mem_dout;
    w_mem_rd_d   = r_mem_rd;
    w_mem_wr_d   = r_mem_wr;
    w_rf_load_d  = r_rf_load;

    unique case (r_state)
      LSU_IDLE: begin
        if (i_sched_req) begin
          w_state_d    = LSU_LO;
          w_adr_d      = i_alu_adr;
          w_pay_hi_d   = i_alu_payload[15:8];
          w_we_d       = i_sched_we;
          w_word_d     = i_sched_word;
          w_fault_d    = 1'b0;
          // Bus signals are set up on the accepting edge so they are valid for all of LO.
          w_mem_adr_d  = i_alu_adr;
          w_mem_dout_d = i_alu_payload[7:0];
          w_mem_rd_d   = !i_sched_we;
          w_mem_wr_d   = i_sched_we;
        end
      end
      LSU_LO: begin
        if (i_mem_rdy) begin
          w_lo_d = i_mem_din;
          if (r_word) begin
            w_state_d    = LSU_HI;
            w_mem_adr_d  = lsu_inc_adr(r_adr, PAGE_WRAP != 0);
            w_mem_dout_d = r_pay_hi;
          end else begin
            w_state_d  = LSU_DONE;
            w_mem_rd_d = 1'b0;
            w_mem_wr_d = 1'b0;
            if (!r_we) begin
              w_rf_load_d = {8'h00, i_mem_din};
            end
          end
        end else if (w_expire) begin
          w_state_d  = LSU_DONE;
          w_fault_d  = 1'b1;
          w_mem_rd_d = 1'b0;
          w_mem_wr_d = 1'b0;
        end
      end
      LSU_HI: begin
        if (i_mem_rdy) begin
          w_state_d  = LSU_DONE;
          w_mem_rd_d = 1'b0;
          w_mem_wr_d = 1'b0;
          if (!r_we) begin
            w_rf_load_d = {i_mem_din, r_lo};
          end
        end else if (w_expire) begin
          w_state_d  = LSU_DONE;
          w_fault_d  = 1'b1;
          w_mem_rd_d = 1'b0;
          w_mem_wr_d = 1'b0;
        end
      end
      LSU_DONE: begin
        w_state_d = LSU_IDLE;
      end
      default: begin
        w_state_d = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= LSU_IDLE;
      r_adr      <= '0;
      r_pay_hi   <= '0;
      r_we       <= 1'b0;
      r_word     <= 1'b0;
      r_lo       <= '0;
      r_fault    <= 1'b0;
      r_mem_adr  <= '0;
      r_mem_dout <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_rf_load  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_adr      <= w_adr_d;
      r_pay_hi   <= w_pay_hi_d;
      r_we       <= w_we_d;
      r_word     <= w_word_d;
      r_lo       <= w_lo_d;
      r_fault    <= w_fault_d;
      r_mem_adr  <= w_mem_adr_d;
      r_mem_dout <= w_mem_dout_d;
      r_mem_rd   <= w_mem_rd_d;
      r_mem_wr   <= w_mem_wr_d;
      r_rf_load  <= w_rf_load_d;
    end
  end

  assign o_lsu_busy   = (r_state != LSU_IDLE);
  assign o_lsu_done   = (r_state == LSU_DONE);
  assign o_lsu_fault  = (r_state == LSU_DONE) && r_fault;
  assign o_rf_load_we = (r_state == LSU_DONE) && !r_we && !r_fault;
  assign o_rf_load    = r_rf_load;
  assign o_mem_adr    = r_mem_adr;
  assign o_mem_dout   = r_mem_dout;
  assign o_mem_rd     = r_mem_rd;
  assign o_mem_wr     = r_mem_wr;

endmodule

// File: tb/tb_lsu_bus_seq.sv
// Bench for lsu_bus_seq: two instances (flat and page-wrapped high-byte address) share stimulus;
// bus beats and transfer results are checked against queued expectations.
module tb_lsu_bus_seq;

  localparam int TO = 4;
  localparam int NV = 10;

  logic        clk, rst;
  logic        sched_req, sched_we, sched_word;
  logic [15:0] alu_adr, alu_payload;
  logic [7:0]  mem_din;
  logic        mem_rdy;

  logic        f_busy, f_done, f_fault, f_rf_we, f_rd, f_wr;
  logic [15:0] f_rf, f_adr;
  logic [7:0]  f_dout;
  logic        p_busy, p_done, p_fault, p_rf_we, p_rd, p_wr;
  logic [15:0] p_rf, p_adr;
  logic [7:0]  p_dout;

  lsu_bus_seq #(.PAGE_WRAP(0), .TIMEOUT(TO)) dut_flat (
    .i_clk(clk), .i_rst(rst), .i_sched_req(sched_req), .i_sched_we(sched_we),
    .i_sched_word(sched_word), .o_lsu_busy(f_busy), .o_lsu_done(f_done), .o_lsu_fault(f_fault),
    .i_alu_adr(alu_adr), .i_alu_payload(alu_payload), .o_rf_load(f_rf), .o_rf_load_we(f_rf_we),
    .o_mem_adr(f_adr), .o_mem_dout(f_dout), .i_mem_din(mem_din), .o_mem_rd(f_rd),
    .o_mem_wr(f_wr), .i_mem_rdy(mem_rdy)
  );

  lsu_bus_seq #(.PAGE_WRAP(1), .TIMEOUT(TO)) dut_page (
    .i_clk(clk), .i_rst(rst), .i_sched_req(sched_req), .i_sched_we(sched_we),
    .i_sched_word(sched_word), .o_lsu_busy(p_busy), .o_lsu_done(p_done), .o_lsu_fault(p_fault),
    .i_alu_adr(alu_adr), .i_alu_payload(alu_payload), .o_rf_load(p_rf), .o_rf_load_we(p_rf_we),
    .o_mem_adr(p_adr), .o_mem_dout(p_dout), .i_mem_din(mem_din), .o_mem_rd(p_rd),
    .o_mem_wr(p_wr), .i_mem_rdy(mem_rdy)
  );

  typedef struct packed {logic we; logic [15:0] adr; logic [7:0] data;} beat_t;
  typedef struct packed {logic fault; logic ld; logic [15:0] rf;} res_t;
  typedef struct {
    logic        we;
    logic        word;
    logic [15:0] adr;
    logic [15:0] pay;
    logic [7:0]  dlo;
    logic [7:0]  dhi;
    int          wlo;
    int          whi;
    logic        exp_fault;
    logic [15:0] exp_rf;
  } vec_t;

  beat_t       q_flat[$];
  beat_t       q_page[$];
  res_t        q_res[$];
  vec_t        vecs[NV];
  int          n_cmp, n_fail, n_done, n_strobe;
  logic [15:0] last_rf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void push_beat(input logic we, input logic [15:0] adr_f,
                                    input logic [15:0] adr_p, input logic [7:0] d);
    q_flat.push_back({we, adr_f, d});
    q_page.push_back({we, adr_p, d});
  endfunction

  // Beats and completions are sampled on the falling edge, half a cycle from any update.
  always @(negedge clk) begin
    beat_t b;
    res_t  r;
    if (!rst) begin
      if (f_rd || f_wr) begin
        n_strobe++;
        chk("strobe_exclusive", {31'b0, f_rd & f_wr}, 32'd0);
      end
      if ((f_rd || f_wr) && mem_rdy) begin
        b = {f_wr, f_adr, f_wr ? f_dout : mem_din};
        if (q_flat.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL flat_beat: unexpected beat %h", b);
        end else begin
          chk("flat_beat", 32'(b), 32'(q_flat.pop_front()));
        end
      end
      if ((p_rd || p_wr) && mem_rdy) begin
        b = {p_wr, p_adr, p_wr ? p_dout : mem_din};
        if (q_page.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL page_beat: unexpected beat %h", b);
        end else begin
          chk("page_beat", 32'(b), 32'(q_page.pop_front()));
        end
      end
      if (f_done) begin
        n_done++;
        if (q_res.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL done: unexpected completion, fault=%b", f_fault);
        end else begin
          r = q_res.pop_front();
          chk("fault", {31'b0, f_fault}, {31'b0, r.fault});
          chk("rf_load_we", {31'b0, f_rf_we}, {31'b0, r.ld & ~r.fault});
          chk("rf_load", {16'b0, f_rf}, {16'b0, r.rf});
        end
      end
    end
  end

  task automatic serve(input logic [7:0] d, input int w);
    mem_din = d;
    for (int c = 0; c < 300; c++) begin
      mem_rdy = (c >= w);
      @(posedge clk);
      #1;
      if (c >= w || c + 1 >= TO) break;
    end
    mem_rdy = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit lo_to, hi_to;
    int exp_strobe, s0;
    lo_to = (v.wlo >= TO);
    hi_to = v.word && !lo_to && (v.whi >= TO);
    if (!lo_to) push_beat(v.we, v.adr, v.adr, v.we ? v.pay[7:0] : v.dlo);
    if (v.word && !lo_to && !hi_to)
      push_beat(v.we, v.adr + 16'd1, {v.adr[15:8], v.adr[7:0] + 8'd1},
                v.we ? v.pay[15:8] : v.dhi);
    if (!v.we && !v.exp_fault) last_rf = v.exp_rf;
    q_res.push_back('{fault: v.exp_fault, ld: !v.we, rf: last_rf});
    exp_strobe = (lo_to ? TO : v.wlo + 1) + ((v.word && !lo_to) ? (hi_to ? TO : v.whi + 1) : 0);
    s0 = n_strobe;
    sched_req   = 1'b1;
    sched_we    = v.we;
    sched_word  = v.word;
    alu_adr     = v.adr;
    alu_payload = v.pay;
    mem_rdy     = 1'b0;
    @(posedge clk);
    #1;
    sched_req = 1'b0;
    serve(v.dlo, v.wlo);
    if (v.word && !lo_to) serve(v.dhi, v.whi);
    chk({tag, "_done_on_time"}, {31'b0, f_done}, 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_idle_after"}, {31'b0, f_busy}, 32'd0);
    chk({tag, "_strobe_cycles"}, n_strobe - s0, exp_strobe);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; n_done = 0; n_strobe = 0; last_rf = 16'h0000;
    sched_req = 0; sched_we = 0; sched_word = 0; alu_adr = '0; alu_payload = '0;
    mem_din = '0; mem_rdy = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", {31'b0, f_busy}, 32'd0);
    chk("rst_done", {31'b0, f_done | p_done}, 32'd0);
    chk("rst_fault", {31'b0, f_fault | p_fault}, 32'd0);
    chk("rst_rf_we", {31'b0, f_rf_we | p_rf_we}, 32'd0);
    chk("rst_rf_load", {f_rf, p_rf}, 32'd0);
    chk("rst_mem_adr", {f_adr, p_adr}, 32'd0);
    chk("rst_mem_dout", {16'b0, f_dout, p_dout}, 32'd0);
    chk("rst_strobes", {28'b0, f_rd, f_wr, p_rd, p_wr}, 32'd0);
    chk("rst_page_busy", {31'b0, p_busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    vecs[0] = '{we:0, word:1, adr:16'h1234, pay:16'h0000, dlo:8'hCD, dhi:8'hAB, wlo:0, whi:0,
                exp_fault:0, exp_rf:16'hABCD};
    vecs[1] = '{we:1, word:1, adr:16'hFFFF, pay:16'hBEEF, dlo:8'h00, dhi:8'h00, wlo:0, whi:0,
                exp_fault:0, exp_rf:16'h0000};
    vecs[2] = '{we:0, word:0, adr:16'h0010, pay:16'h0000, dlo:8'h80, dhi:8'h00, wlo:2, whi:0,
                exp_fault:0, exp_rf:16'h0080};
    vecs[3] = '{we:1, word:0, adr:16'h00FF, pay:16'h1277, dlo:8'h00, dhi:8'h00, wlo:1, whi:0,
                exp_fault:0, exp_rf:16'h0000};
    vecs[4] = '{we:0, word:1, adr:16'h12FF, pay:16'h0000, dlo:8'h11, dhi:8'h22, wlo:1, whi:3,
                exp_fault:0, exp_rf:16'h2211};
    vecs[5] = '{we:0, word:1, adr:16'h4000, pay:16'h0000, dlo:8'h99, dhi:8'h88, wlo:9, whi:0,
                exp_fault:1, exp_rf:16'h0000};
    vecs[6] = '{we:1, word:1, adr:16'h5555, pay:16'hA1B2, dlo:8'h00, dhi:8'h00, wlo:0, whi:7,
                exp_fault:1, exp_rf:16'h0000};
    vecs[7] = '{we:0, word:0, adr:16'h0001, pay:16'h0000, dlo:8'hFF, dhi:8'h00, wlo:3, whi:0,
                exp_fault:0, exp_rf:16'h00FF};
    vecs[8] = '{we:1, word:1, adr:16'h0000, pay:16'h0102, dlo:8'h00, dhi:8'h00, wlo:2, whi:1,
                exp_fault:0, exp_rf:16'h0000};
    vecs[9] = '{we:0, word:1, adr:16'h80FF, pay:16'h0000, dlo:8'h34, dhi:8'h12, wlo:0, whi:0,
                exp_fault:0, exp_rf:16'h1234};

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted during the high byte of a word store.
    push_beat(1'b1, 16'h2000, 16'h2000, 8'h34);
    sched_req = 1; sched_we = 1; sched_word = 1; alu_adr = 16'h2000; alu_payload = 16'h1234;
    mem_rdy = 0;
    @(posedge clk);
    #1;
    sched_req = 0;
    mem_rdy = 1;
    @(posedge clk);
    #1;
    mem_rdy = 0;
    chk("rsthi_wr_before", {31'b0, f_wr}, 32'd1);
    chk("rsthi_adr_before", {16'b0, f_adr}, 32'h2001);
    #1 rst = 1'b1;
    #1;
    chk("rsthi_wr_drop", {30'b0, f_wr, p_wr}, 32'd0);
    chk("rsthi_busy", {31'b0, f_busy}, 32'd0);
    chk("rsthi_adr_clear", {16'b0, f_adr}, 32'd0);
    chk("rsthi_rf_clear", {16'b0, f_rf}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    last_rf = 16'h0000;
    @(posedge clk);
    #1;
    run_vec(vecs[0], "post_rst");

    // Request held high across completion: next accept only after the IDLE cycle.
    push_beat(1'b0, 16'h3000, 16'h3000, 8'h5A);
    q_res.push_back('{fault: 1'b0, ld: 1'b1, rf: 16'h005A});
    push_beat(1'b0, 16'h3100, 16'h3100, 8'h6B);
    q_res.push_back('{fault: 1'b0, ld: 1'b1, rf: 16'h006B});
    last_rf = 16'h006B;
    sched_req = 1; sched_we = 0; sched_word = 0; alu_adr = 16'h3000; mem_rdy = 1; mem_din = 8'h5A;
    @(posedge clk);
    #1;
    alu_adr = 16'h3100;
    chk("b2b_first_rd", {31'b0, f_rd}, 32'd1);
    @(posedge clk);
    #1;
    chk("b2b_first_done", {31'b0, f_done}, 32'd1);
    chk("b2b_no_strobe_in_done", {30'b0, f_rd, f_wr}, 32'd0);
    mem_din = 8'h6B;
    @(posedge clk);
    #1;
    chk("b2b_idle_gap", {31'b0, f_busy}, 32'd0);
    chk("b2b_no_strobe_in_idle", {30'b0, f_rd, f_wr}, 32'd0);
    @(posedge clk);
    #1;
    sched_req = 0;
    chk("b2b_second_accept", {31'b0, f_busy}, 32'd1);
    chk("b2b_second_adr", {16'b0, f_adr}, 32'h3100);
    @(posedge clk);
    #1;
    chk("b2b_second_done", {31'b0, f_done}, 32'd1);
    @(posedge clk);
    #1;
    mem_rdy = 0;
    chk("b2b_idle_end", {31'b0, f_busy}, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("flat_queue_empty", q_flat.size(), 32'd0);
    chk("page_queue_empty", q_page.size(), 32'd0);
    chk("result_queue_empty", q_res.size(), 32'd0);
    chk("done_pulse_count", n_done, NV + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
